// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: opcodes, time-steps,
// operand-mux selects and instruction field positions.
package proc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned NREGS   = 8;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned IMM_BIT = 12;
  localparam int unsigned RX_MSB  = 11;
  localparam int unsigned RX_LSB  = 9;
  localparam int unsigned RY_MSB  = 2;
  localparam int unsigned RY_LSB  = 0;
  localparam int unsigned IMM9_MSB = 8;
  localparam int unsigned IMM9_LSB = 0;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [SEL_W-1:0] SEL_G    = 4'd8;
  localparam logic [SEL_W-1:0] SEL_SEXT = 4'd9;
  localparam logic [SEL_W-1:0] SEL_MVT  = 4'd10;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstep_t;

endpackage

// File: rtl/proc_sequencer_dec3to8.sv
// 3-to-8 one-hot decoder with enable; drives the register write enables.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] w,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y = 8'(1) << w;
  end

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle control FSM for the 16-bit processor datapath: steps T0-T3,
// drives register enables, mux select and ALU mode, counts retired instructions.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               Rest,
  input  logic               Run,
  input  logic [15:0]        instr,
  output logic               IRin,
  output logic [7:0]         Rin,
  output logic               Ain,
  output logic               Gin,
  output logic               addsub,
  output logic [3:0]         sel,
  output logic               Done,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   icount
);

  tstep_t cur_state, nxt_state;
  logic   rin_en;

  logic [2:0]       opcode;
  logic [2:0]       rx;
  logic [SEL_W-1:0] op2_sel;
  logic             unused_imm;

  assign opcode  = instr[OPC_MSB:OPC_LSB];
  assign rx      = instr[RX_MSB:RX_LSB];
  assign op2_sel = instr[IMM_BIT] ? SEL_SEXT : {1'b0, instr[RY_MSB:RY_LSB]};
  // Immediate value bits only matter to the datapath mux
  assign unused_imm = ^instr[RX_LSB-1:RY_MSB+1];

  assign state = cur_state;

  // State and retired-instruction counter
  always_ff @(posedge clk or posedge Rest) begin
    if (Rest) begin
      cur_state <= T0;
      icount    <= '0;
    end else begin
      cur_state <= nxt_state;
      if (Done) icount <= icount + CNT_W'(1);
    end
  end

  // Next-state and control decode
  always_comb begin
    nxt_state = cur_state;
    IRin      = 1'b0;
    rin_en    = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    addsub    = 1'b0;
    sel       = '0;
    Done      = 1'b0;

    unique case (cur_state)
      T0: begin
        IRin = Run;
        if (Run) nxt_state = T1;
      end
      T1: begin
        unique case (opcode)
          OP_MV: begin
            rin_en    = 1'b1;
            sel       = op2_sel;
            Done      = 1'b1;
            nxt_state = T0;
          end
          OP_MVT: begin
            rin_en    = 1'b1;
            sel       = SEL_MVT;
            Done      = 1'b1;
            nxt_state = T0;
          end
          OP_ADD, OP_SUB: begin
            Ain       = 1'b1;
            sel       = {1'b0, rx};
            nxt_state = T2;
          end
          default: begin
            Done      = 1'b1;
            nxt_state = T0;
          end
        endcase
      end
      T2: begin
        sel       = op2_sel;
        Gin       = 1'b1;
        addsub    = (opcode == OP_SUB);
        nxt_state = T3;
      end
      T3: begin
        sel       = SEL_G;
        rin_en    = 1'b1;
        Done      = 1'b1;
        nxt_state = T0;
      end
      default: nxt_state = T0;
    endcase

    // Reset silences every control output, including a pending fetch
    if (Rest) begin
      IRin   = 1'b0;
      rin_en = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      addsub = 1'b0;
      sel    = '0;
      Done   = 1'b0;
    end
  end

  dec3to8 u_dec (
    .en (rin_en),
    .w  (rx),
    .y  (Rin)
  );

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed and random instructions
// against a per-step behavioural model; a CNT_W=2 copy exercises counter wrap.
module tb_proc_sequencer;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic [3:0] sel;
    logic       done;
    logic [1:0] st;
  } exp_t;

  logic        clk = 1'b0;
  logic        Rest;
  logic        Run;
  logic [15:0] instr;

  logic        IRin1, Ain1, Gin1, addsub1, Done1;
  logic [7:0]  Rin1;
  logic [3:0]  sel1;
  logic [1:0]  state1;
  logic [15:0] icount1;

  logic        IRin2, Ain2, Gin2, addsub2, Done2;
  logic [7:0]  Rin2;
  logic [3:0]  sel2;
  logic [1:0]  state2;
  logic [1:0]  icount2;

  int errors = 0;
  int checks = 0;
  int unsigned cnt = 0;

  always #5 clk = ~clk;

  proc_sequencer #(.CNT_W(16)) dut16 (
    .clk(clk), .Rest(Rest), .Run(Run), .instr(instr),
    .IRin(IRin1), .Rin(Rin1), .Ain(Ain1), .Gin(Gin1), .addsub(addsub1),
    .sel(sel1), .Done(Done1), .state(state1), .icount(icount1)
  );

  proc_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .Rest(Rest), .Run(Run), .instr(instr),
    .IRin(IRin2), .Rin(Rin2), .Ain(Ain2), .Gin(Gin2), .addsub(addsub2),
    .sel(sel2), .Done(Done2), .state(state2), .icount(icount2)
  );

  logic [18:0] obs1, obs2;
  assign obs1 = {IRin1, Rin1, Ain1, Gin1, addsub1, sel1, Done1, state1};
  assign obs2 = {IRin2, Rin2, Ain2, Gin2, addsub2, sel2, Done2, state2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of time-steps an instruction occupies, fetch included
  function automatic int nsteps(input logic [15:0] ins);
    case (ins[15:13])
      3'd2, 3'd3: return 4;
      default:    return 2;
    endcase
  endfunction

  // Expected outputs for step k of an instruction, straight from the opcode rules
  function automatic exp_t exp_step(input logic [15:0] ins, input int k);
    exp_t       e;
    logic [2:0] op, rx;
    logic [3:0] op2;
    logic [7:0] onehot;
    e      = '0;
    op     = ins[15:13];
    rx     = ins[11:9];
    op2    = ins[12] ? 4'd9 : {1'b0, ins[2:0]};
    onehot = 8'(1) << rx;
    e.st   = 2'(k);
    if (k == 0) begin
      e.irin = 1'b1;
    end else if (op == 3'd0) begin
      e.rin = onehot; e.sel = op2; e.done = 1'b1;
    end else if (op == 3'd1) begin
      e.rin = onehot; e.sel = 4'd10; e.done = 1'b1;
    end else if (op == 3'd2 || op == 3'd3) begin
      if (k == 1) begin
        e.ain = 1'b1; e.sel = {1'b0, rx};
      end else if (k == 2) begin
        e.gin = 1'b1; e.sel = op2; e.addsub = (op == 3'd3);
      end else begin
        e.sel = 4'd8; e.rin = onehot; e.done = 1'b1;
      end
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  // One clock: sample at negedge, advance model on the posedge
  task automatic cycle(input exp_t e, input string tag);
    @(negedge clk);
    chk({tag, " out16"}, 32'(obs1), 32'(e));
    chk({tag, " out2"}, 32'(obs2), 32'(e));
    chk({tag, " icount16"}, 32'(icount1), 32'(cnt[15:0]));
    chk({tag, " icount2"}, 32'(icount2), 32'(cnt[1:0]));
    @(posedge clk);
    if (e.done) cnt++;
    #1;
  endtask

  // run_mode: 0 = Run dropped after fetch, 1 = held high, 2 = random
  task automatic run_instr(input logic [15:0] ins, input int run_mode, input string tag);
    instr = ins;
    Run   = 1'b1;
    for (int k = 0; k < nsteps(ins); k++) begin
      if (k > 0)
        Run = (run_mode == 1) ? 1'b1 : (run_mode == 2) ? 1'($urandom) : 1'b0;
      cycle(exp_step(ins, k), tag);
    end
  endtask

  task automatic idle(input string tag);
    exp_t e;
    e   = '0;
    Run = 1'b0;
    cycle(e, tag);
  endtask

  initial begin
    exp_t z;
    z     = '0;
    Rest  = 1'b1;
    Run   = 1'b1;
    instr = 16'h4403;
    #3;
    chk("reset_init out16", 32'(obs1), 32'(z));
    chk("reset_init icount16", 32'(icount1), 32'd0);
    @(posedge clk);
    #1;
    Rest = 1'b0;
    Run  = 1'b0;

    idle("idle0");
    run_instr(16'h1E05, 0, "mv_imm");
    idle("idle1");
    run_instr(16'h3201, 0, "mvt");
    run_instr(16'h4403, 0, "add");
    run_instr(16'h71FF, 1, "sub_imm_b2b");
    run_instr(16'h8000, 1, "nop_b2b");
    chk("after_b2b icount", 32'(icount1), 32'(cnt));
    idle("idle2");

    // Reset in the middle of T2 of an add, with Run high
    instr = 16'h4403;
    Run   = 1'b1;
    cycle(exp_step(16'h4403, 0), "rst_add_t0");
    cycle(exp_step(16'h4403, 1), "rst_add_t1");
    @(negedge clk);
    chk("rst_add_t2 out16", 32'(obs1), 32'(exp_step(16'h4403, 2)));
    #1;
    Rest = 1'b1;
    #1;
    cnt = 0;
    chk("rst_async out16", 32'(obs1), 32'(z));
    chk("rst_async out2", 32'(obs2), 32'(z));
    chk("rst_async icount16", 32'(icount1), 32'd0);
    chk("rst_async icount2", 32'(icount2), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold out16", 32'(obs1), 32'(z));
    chk("rst_hold icount16", 32'(icount1), 32'd0);
    Rest = 1'b0;

    // First fetch on the first edge after reset release
    run_instr(16'h0A03, 2, "post_rst_mv");

    // Wrap of the 2-bit counter with Run toggling mid-instruction
    for (int n = 0; n < 5; n++) run_instr(16'h4C01, 2, "wrap_add");

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3) == 0) idle("rnd_idle");
      run_instr(16'($urandom), 2, "rnd");
    end
    idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
